// File: rtl/seq_stream_scheduler_pkg.sv
// Shared types and defaults for the sequence-detector stream scheduler.
// Optional feature macro (used by rr_arbiter): SEQ_SCHED_PRIO0_EN.
package seq_sched_pkg;

    localparam int NREQ_DEFAULT   = 4;
    localparam int WORD_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } sched_state_t;

    // Limit a requested job length to the number of bits a job word holds.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_stream_scheduler_if.sv
// Bundle of requester, detector and result signals around the scheduler.
// master: the environment (requesters, detector, result consumer).
// slave:  the scheduler itself.
interface seq_stream_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16,
    parameter int LEN_W  = $clog2(WORD_W + 1),
    parameter int ID_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic                   det_rst;
    logic                   det_ena;
    logic                   det_sig;
    logic                   det_z;
    logic                   done_valid;
    logic                   done_ready;
    logic [ID_W-1:0]        done_id;
    logic [LEN_W-1:0]       done_hits;

    modport master (
        output req_valid, req_data, req_len, det_z, done_ready,
        input  req_ready, det_rst, det_ena, det_sig, done_valid, done_id, done_hits
    );

    modport slave (
        input  req_valid, req_data, req_len, det_z, done_ready,
        output req_ready, det_rst, det_ena, det_sig, done_valid, done_id, done_hits
    );
endinterface

// File: rtl/seq_stream_scheduler_rr_arbiter.sv
// Round-robin arbiter owning the rotating pointer.
// Macro SEQ_SCHED_PRIO0_EN: requester 0 wins whenever it requests and the
// pointer then rotates only over requesters 1..NREQ-1.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

`ifdef SEQ_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic [ID_W-1:0] ptr_reg;

    // Pick the first requester at or after the pointer (wrapping); with the
    // priority option, requester 0 pre-empts and is excluded from the rotation.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (PRIO0 && req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!found && req[idx] && !(PRIO0 && idx == 0)) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Pointer moves past the winner on each accept; a priority grant to
    // requester 0 leaves the rotation among the others untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (advance && !(PRIO0 && grant_idx == '0)) begin
            ptr_reg <= (int'(grant_idx) == NREQ - 1) ? '0 : ID_W'(int'(grant_idx) + 1);
        end
    end

endmodule

// File: rtl/seq_stream_scheduler.sv
// Shares one sequence detector among NREQ requesters: accepts a job
// round-robin, clears the detector, shifts the job bits in LSB first, counts
// detector hits and returns the count tagged with the requester ID.
// Optional feature macro (in rr_arbiter): SEQ_SCHED_PRIO0_EN.
module seq_stream_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEFAULT,
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int LEN_W  = $clog2(WORD_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_stream_scheduler_if.slave  bus
);

    localparam int ID_W = $clog2(NREQ);

    sched_state_t      state_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [LEN_W-1:0]  hits_reg;
    logic [ID_W-1:0]   id_reg;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              is_idle;
    logic              accept;

    logic [WORD_W-1:0] data_slice [NREQ];
    logic [LEN_W-1:0]  len_slice  [NREQ];

    // Per-requester job word and clamped length, ready for selection by grant.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign data_slice[gi] = bus.req_data[gi*WORD_W +: WORD_W];
            assign len_slice[gi]  = LEN_W'(clamp_len(int'(bus.req_len[gi*LEN_W +: LEN_W]), WORD_W));
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign is_idle       = !rst && (state_reg == IDLE);
    assign accept        = is_idle && (|grant);
    assign bus.req_ready = is_idle ? grant : '0;

    assign bus.det_rst    = rst || (state_reg == CLEAR);
    assign bus.det_ena    = !rst && (state_reg == SHIFT);
    assign bus.det_sig    = bus.det_ena && shift_reg[0];
    assign bus.done_valid = !rst && (state_reg == REPORT);
    assign bus.done_id    = rst ? '0 : id_reg;
    assign bus.done_hits  = rst ? '0 : hits_reg;

    // Job FSM: latch on accept, one detector-clear cycle, one bit per cycle
    // with same-cycle hit sampling, then hold the result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            hits_reg  <= '0;
            id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= data_slice[grant_idx];
                        cnt_reg   <= len_slice[grant_idx];
                        id_reg    <= grant_idx;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    hits_reg  <= '0;
                    state_reg <= (cnt_reg != '0) ? SHIFT : REPORT;
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    cnt_reg   <= cnt_reg - 1'b1;
                    if (bus.det_z) begin
                        hits_reg <= hits_reg + 1'b1;
                    end
                    if (cnt_reg <= LEN_W'(1)) begin
                        state_reg <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.done_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_stream_scheduler.md
# seq_stream_scheduler

Shares one `sequence_detector` instance among several requesters. Each requester submits a job: a bit word plus a length. The block picks jobs round-robin, clears the detector, and serializes the bits into it one per cycle. It counts the detector's `z` pulses and returns the per-job hit count with the requester ID. It sits between the switch/LFSR/UART bit sources and the detector/7-segment datapath.

## Interface
- `NREQ`, 4: number of requesters (2–8).
- `WORD_W`, 16: maximum job length in bits.
- `LEN_W`, `$clog2(WORD_W+1)`: width of the length and hit-count fields.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: job offered by requester i.
- `req_ready` out NREQ: one-hot accept strobe.
- `req_data` in NREQ*WORD_W: job bits, requester i in slice i, sent LSB first.
- `req_len` in NREQ*LEN_W: job length, requester i in slice i.
- `det_rst` out 1: detector reset.
- `det_ena` out 1: detector enable.
- `det_sig` out 1: detector serial input (`sig_to_test`).
- `det_z` in 1: detector Mealy output, combinational from state and `det_sig`.
- `done_valid` out 1: result available.
- `done_ready` in 1: result consumer ready.
- `done_id` out `$clog2(NREQ)`: ID of the requester that owned the job.
- `done_hits` out LEN_W: number of `z` hits in the job.

## Operation
States (one-hot-free enum) and transitions:
- IDLE:
  - The arbiter picks a winner among asserted `req_valid`.
  - `req_ready[winner]`=1 combinationally in the same cycle.
  - On that cycle, data, len and id are latched; next state is CLEAR.
  - With no request, the block stays in IDLE.
- CLEAR:
  - `det_rst`=1 for exactly 1 cycle.
  - Hit counter is cleared.
  - Next state is SHIFT if len>0, else REPORT.
- SHIFT:
  - `det_ena`=1 and `det_sig`=shift_reg[0].
  - shift_reg shifts right each cycle and the remaining-bit counter decrements.
  - hits += 1 in every cycle where `det_ena & det_z`.
  - Leaves for REPORT after the last bit.
- REPORT:
  - `done_valid`=1, with `done_id` and `done_hits` stable.
  - Holds until `done_valid & done_ready`, then goes to IDLE.

Arbitration:
- Round-robin.
- The pointer advances to winner+1 (mod NREQ) only on accept.
- Requests are not latched: a requester keeps `req_valid` high until it sees `req_ready`.

Rules and boundary conditions:
- `req_len` > WORD_W is clamped to WORD_W.
- len=0 gives hits=0 with no detector enable cycles.
- `done_hits` cannot overflow because hits ≤ len ≤ WORD_W.
- `req_valid` dropped while the block is busy has no effect.
- `det_rst` = `rst` OR (state==CLEAR).
- `det_ena`=0 and `det_sig`=0 outside SHIFT.
- `rst` mid-job:
  - The job is abandoned and no result is produced.
  - State goes to IDLE and the RR pointer to 0.
- Reset values: `req_ready`=0, `det_ena`=0, `det_sig`=0, `det_rst`=1, `done_valid`=0, `done_id`=0, `done_hits`=0.

## Timing
- Accept at cycle T.
- CLEAR at T+1.
- Bits occupy cycles T+2 … T+1+len.
- `done_valid` rises at T+2+len (T+2 when len=0).
- Minimum gap between results is one IDLE cycle: the next accept can happen no earlier than the cycle after the done handshake.
- `done_ready` high on the first REPORT cycle gives a 1-cycle REPORT.
- Hit sampling happens in the same cycle as `det_sig`, with no extra pipeline stage.

## Configuration
- Macro: `SEQ_SCHED_PRIO0_EN`.
- Defined: requester 0 has fixed priority over all others whenever its `req_valid` is high. The RR pointer is then used only among requesters 1..NREQ-1.
- Undefined: pure round-robin over all NREQ requesters.

## Structure
- `seq_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, CLEAR, SHIFT, REPORT);
  - default `WORD_W`/`NREQ` constants.
- Sub-module `rr_arbiter`:
  - ports: req vector, advance strobe, one-hot grant, grant index;
  - owns the RR pointer and the `SEQ_SCHED_PRIO0_EN` logic.
- The top level owns the FSM, shift register, length counter and hit counter.

## Test plan
All scenarios use a behavioral detector model matching 01[0*]1.
- Requester 1: data=0x12, len=5 (bits 0,1,0,0,1) → `done_id`=1, `done_hits`=1. `done_valid` rises 7 cycles after accept, and `det_ena` is high for exactly 5 cycles.
- Requester 2: data=0xFFFF, len=16 → `done_hits`=0. `det_rst` pulses once, in the cycle after accept.
- Requester 0: len=0 → `done_hits`=0 at accept+2, and `det_ena` never asserts.
- All 4 requesters valid continuously with macro undefined → accepts in order 0,1,2,3,0. With `SEQ_SCHED_PRIO0_EN` → accepts 0,0,0 while req 0 stays valid.
- `done_ready` held low for 10 cycles → `done_valid`, `done_id` and `done_hits` stay stable, and no `req_ready` is asserted.
- `rst` asserted mid-SHIFT → next cycle is IDLE with all outputs at reset values, no `done_valid` for that job, and the next accept goes to requester 0.
